shift_mark_sram_mux: RTL and testbench

//  Downstream of shift_mark: merges its SRAM read/write requests with those of the bloom mark (hash update) path

---
 rtl/shift_mark_sram_mux_pkg.sv | 24 ++
 rtl/shift_mark_sram_mux_tag_fifo.sv | 52 +++++
 rtl/shift_mark_sram_mux.sv | 243 ++++++++++++++++++++++++
 tb/tb_shift_mark_sram_mux.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_mark_sram_mux_pkg.sv
// Shared definitions for the shift/mark SRAM request mux: client ids, arbiter states, defaults.
package shift_mark_sram_mux_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH_DEF = 19;
  localparam int unsigned SRAM_DATA_WIDTH_DEF = 72;
  localparam int unsigned TAG_DEPTH_BITS_DEF  = 3;

  localparam logic CLI_SHI = 1'b0;
  localparam logic CLI_MRK = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    ISSUE    = 3'b010,
    WAIT_ACK = 3'b100
  } arb_state_t;

  // Round-robin choice over {mrk, shi} pending bits; ptr names the favoured client.
  function automatic logic rr_pick(input logic [1:0] pend, input logic ptr);
    if (pend[0] && pend[1]) return ptr;
    else if (pend[1])       return CLI_MRK;
    else                    return CLI_SHI;
  endfunction

endpackage

// File: rtl/shift_mark_sram_mux_tag_fifo.sv
// Small first-word-fallthrough FIFO; used to remember which client owns each outstanding read.
module fallthrough_small_fifo_old #(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = (MAX_DEPTH_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      do_wr;
  logic                      do_rd;

  assign empty = (depth == '0);
  assign full  = (depth == FULL_CNT);
  assign dout  = mem[rd_ptr];
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      if (do_rd) rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
      case ({do_wr, do_rd})
        2'b10:   depth <= depth + (MAX_DEPTH_BITS+1)'(1);
        2'b01:   depth <= depth - (MAX_DEPTH_BITS+1)'(1);
        default: depth <= depth;
      endcase
    end
  end

endmodule

// File: rtl/shift_mark_sram_mux.sv
// Merges shift and mark client SRAM requests onto one rd/wr port pair with per-direction
// round-robin arbitration; read returns are routed back in order via a client-id tag FIFO.
module shift_mark_sram_mux
  import shift_mark_sram_mux_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH = 19,
  parameter int unsigned SRAM_DATA_WIDTH = 72,
  parameter int unsigned TAG_DEPTH_BITS  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_shi_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_shi_addr,
  output logic                       rd_shi_ack,
  output logic                       rd_shi_vld,
  output logic [SRAM_DATA_WIDTH-1:0] rd_shi_data,
  input  logic                       wr_shi_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_shi_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] wr_shi_data,
  output logic                       wr_shi_ack,
  input  logic                       rd_mrk_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_mrk_addr,
  output logic                       rd_mrk_ack,
  output logic                       rd_mrk_vld,
  output logic [SRAM_DATA_WIDTH-1:0] rd_mrk_data,
  input  logic                       wr_mrk_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_mrk_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] wr_mrk_data,
  output logic                       wr_mrk_ack,
  output logic                       rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic                       rd_ack,
  input  logic [SRAM_DATA_WIDTH-1:0] rd_data,
  input  logic                       rd_vld,
  output logic                       wr_req,
  output logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0] wr_data,
  input  logic                       wr_ack,
  output logic                       proto_err
);

  localparam int unsigned AW = SRAM_ADDR_WIDTH;
  localparam int unsigned DW = SRAM_DATA_WIDTH;

  // ---------------- read side ----------------
  logic [1:0]    rd_req_v;
  logic [AW-1:0] rd_in_addr [2];
  logic [1:0]    rd_pend;
  logic [AW-1:0] rd_pend_addr [2];
  arb_state_t    rd_state;
  logic          rd_ptr;
  logic          rd_gnt;
  logic          rd_pick;
  logic          rd_start;
  logic [1:0]    rd_clr;
  logic          rd_err_evt;

  logic tag_push, tag_pop, tag_dout, tag_full, tag_empty;

  assign rd_req_v      = {rd_mrk_req, rd_shi_req};
  assign rd_in_addr[0] = rd_shi_addr;
  assign rd_in_addr[1] = rd_mrk_addr;
  assign tag_push      = (rd_state == WAIT_ACK) && rd_ack;
  assign tag_pop       = rd_vld && !tag_empty;

  always_comb begin
    rd_pick    = rr_pick(rd_pend, rd_ptr);
    rd_start   = (rd_state == IDLE) && (|rd_pend) && !tag_full;
    rd_clr     = tag_push ? (2'b01 << rd_gnt) : 2'b00;
    rd_err_evt = (|(rd_req_v & rd_pend)) || (rd_vld && tag_empty);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_pend     <= '0;
      for (int unsigned i = 0; i < 2; i++) rd_pend_addr[i] <= '0;
      rd_state    <= IDLE;
      rd_ptr      <= CLI_SHI;
      rd_gnt      <= CLI_SHI;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      rd_shi_ack  <= 1'b0;
      rd_mrk_ack  <= 1'b0;
      rd_shi_vld  <= 1'b0;
      rd_mrk_vld  <= 1'b0;
      rd_shi_data <= '0;
      rd_mrk_data <= '0;
    end else begin
      rd_shi_ack <= 1'b0;
      rd_mrk_ack <= 1'b0;
      rd_shi_vld <= 1'b0;
      rd_mrk_vld <= 1'b0;

      for (int unsigned i = 0; i < 2; i++) begin
        if (rd_clr[i]) begin
          rd_pend[i] <= 1'b0;
        end else if (rd_req_v[i] && !rd_pend[i]) begin
          rd_pend[i]      <= 1'b1;
          rd_pend_addr[i] <= rd_in_addr[i];
        end
      end

      case (rd_state)
        IDLE: begin
          if (rd_start) begin
            rd_gnt   <= rd_pick;
            rd_ptr   <= ~rd_pick;
            rd_req   <= 1'b1;
            rd_addr  <= rd_pend_addr[rd_pick];
            rd_state <= ISSUE;
          end
        end
        ISSUE: begin
          rd_req   <= 1'b0;
          rd_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (rd_ack) begin
            if (rd_gnt == CLI_MRK) rd_mrk_ack <= 1'b1;
            else                   rd_shi_ack <= 1'b1;
            rd_state <= IDLE;
          end
        end
        default: rd_state <= IDLE;
      endcase

      if (tag_pop) begin
        if (tag_dout == CLI_MRK) begin
          rd_mrk_vld  <= 1'b1;
          rd_mrk_data <= rd_data;
        end else begin
          rd_shi_vld  <= 1'b1;
          rd_shi_data <= rd_data;
        end
      end
    end
  end

  fallthrough_small_fifo_old #(
    .WIDTH          (1),
    .MAX_DEPTH_BITS (TAG_DEPTH_BITS)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (~reset),
    .din   (rd_gnt),
    .wr_en (tag_push),
    .rd_en (tag_pop),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // ---------------- write side ----------------
  logic [1:0]    wr_req_v;
  logic [AW-1:0] wr_in_addr [2];
  logic [DW-1:0] wr_in_data [2];
  logic [1:0]    wr_pend;
  logic [AW-1:0] wr_pend_addr [2];
  logic [DW-1:0] wr_pend_data [2];
  arb_state_t    wr_state;
  logic          wr_ptr;
  logic          wr_gnt;
  logic          wr_pick;
  logic          wr_start;
  logic [1:0]    wr_clr;
  logic          wr_err_evt;

  assign wr_req_v      = {wr_mrk_req, wr_shi_req};
  assign wr_in_addr[0] = wr_shi_addr;
  assign wr_in_addr[1] = wr_mrk_addr;
  assign wr_in_data[0] = wr_shi_data;
  assign wr_in_data[1] = wr_mrk_data;

  always_comb begin
    wr_pick    = rr_pick(wr_pend, wr_ptr);
    wr_start   = (wr_state == IDLE) && (|wr_pend);
    wr_clr     = ((wr_state == WAIT_ACK) && wr_ack) ? (2'b01 << wr_gnt) : 2'b00;
    wr_err_evt = |(wr_req_v & wr_pend);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_pend    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        wr_pend_addr[i] <= '0;
        wr_pend_data[i] <= '0;
      end
      wr_state   <= IDLE;
      wr_ptr     <= CLI_SHI;
      wr_gnt     <= CLI_SHI;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_shi_ack <= 1'b0;
      wr_mrk_ack <= 1'b0;
    end else begin
      wr_shi_ack <= 1'b0;
      wr_mrk_ack <= 1'b0;

      for (int unsigned i = 0; i < 2; i++) begin
        if (wr_clr[i]) begin
          wr_pend[i] <= 1'b0;
        end else if (wr_req_v[i] && !wr_pend[i]) begin
          wr_pend[i]      <= 1'b1;
          wr_pend_addr[i] <= wr_in_addr[i];
          wr_pend_data[i] <= wr_in_data[i];
        end
      end

      case (wr_state)
        IDLE: begin
          if (wr_start) begin
            wr_gnt   <= wr_pick;
            wr_ptr   <= ~wr_pick;
            wr_req   <= 1'b1;
            wr_addr  <= wr_pend_addr[wr_pick];
            wr_data  <= wr_pend_data[wr_pick];
            wr_state <= ISSUE;
          end
        end
        ISSUE: begin
          wr_req   <= 1'b0;
          wr_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (wr_ack) begin
            if (wr_gnt == CLI_MRK) wr_mrk_ack <= 1'b1;
            else                   wr_shi_ack <= 1'b1;
            wr_state <= IDLE;
          end
        end
        default: wr_state <= IDLE;
      endcase
    end
  end

  // Protocol errors from both directions fold into one sticky flag.
  always_ff @(posedge clk) begin
    if (!reset) proto_err <= 1'b0;
    else if (rd_err_evt || wr_err_evt) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_shift_mark_sram_mux.sv
// Scoreboard bench for shift_mark_sram_mux: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_shift_mark_sram_mux;

  localparam int AW = 19;
  localparam int DW = 72;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          rd_shi_req = 1'b0, rd_mrk_req = 1'b0, wr_shi_req = 1'b0, wr_mrk_req = 1'b0;
  logic [AW-1:0] rd_shi_addr = '0, rd_mrk_addr = '0, wr_shi_addr = '0, wr_mrk_addr = '0;
  logic [DW-1:0] wr_shi_data = '0, wr_mrk_data = '0, rd_data = '0;
  logic          rd_ack = 1'b0, rd_vld = 1'b0, wr_ack = 1'b0;
  logic          rd_shi_ack, rd_shi_vld, wr_shi_ack, rd_mrk_ack, rd_mrk_vld, wr_mrk_ack;
  logic [DW-1:0] rd_shi_data, rd_mrk_data, wr_data;
  logic          rd_req, wr_req, proto_err;
  logic [AW-1:0] rd_addr, wr_addr;

  shift_mark_sram_mux #(
    .SRAM_ADDR_WIDTH (AW),
    .SRAM_DATA_WIDTH (DW),
    .TAG_DEPTH_BITS  (3)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_shi_req(rd_shi_req), .rd_shi_addr(rd_shi_addr), .rd_shi_ack(rd_shi_ack),
    .rd_shi_vld(rd_shi_vld), .rd_shi_data(rd_shi_data),
    .wr_shi_req(wr_shi_req), .wr_shi_addr(wr_shi_addr), .wr_shi_data(wr_shi_data), .wr_shi_ack(wr_shi_ack),
    .rd_mrk_req(rd_mrk_req), .rd_mrk_addr(rd_mrk_addr), .rd_mrk_ack(rd_mrk_ack),
    .rd_mrk_vld(rd_mrk_vld), .rd_mrk_data(rd_mrk_data),
    .wr_mrk_req(wr_mrk_req), .wr_mrk_addr(wr_mrk_addr), .wr_mrk_data(wr_mrk_data), .wr_mrk_ack(wr_mrk_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_vld(rd_vld),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .proto_err(proto_err)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic [AW-1:0] exp_rd_addr[$];
  logic [AW-1:0] exp_wr_addr[$];
  logic [DW-1:0] exp_wr_data[$];
  logic [DW-1:0] exp_shi_data[$];
  logic [DW-1:0] exp_mrk_data[$];

  localparam int EV_RDREQ = 0, EV_WRREQ = 1, EV_SHI_ACK = 2, EV_MRK_ACK = 3;
  localparam int EV_WSHI_ACK = 4, EV_WMRK_ACK = 5, EV_SHI_VLD = 6, EV_MRK_VLD = 7;
  int ev[8];
  int base[8];

  initial for (int i = 0; i < 8; i++) ev[i] = 0;

  // Monitor: every DUT output event is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (reset) begin
      if (rd_req) begin
        ev[EV_RDREQ]++;
        if (exp_rd_addr.size() == 0) chk("rd_req_unexpected", 1'b0, 1'b1);
        else chk("rd_addr", rd_addr, exp_rd_addr.pop_front());
      end
      if (wr_req) begin
        ev[EV_WRREQ]++;
        if (exp_wr_addr.size() == 0) chk("wr_req_unexpected", 1'b0, 1'b1);
        else begin
          chk("wr_addr", wr_addr, exp_wr_addr.pop_front());
          chk("wr_data", wr_data, exp_wr_data.pop_front());
        end
      end
      if (rd_shi_vld) begin
        ev[EV_SHI_VLD]++;
        if (exp_shi_data.size() == 0) chk("shi_vld_unexpected", 1'b0, 1'b1);
        else chk("rd_shi_data", rd_shi_data, exp_shi_data.pop_front());
      end
      if (rd_mrk_vld) begin
        ev[EV_MRK_VLD]++;
        if (exp_mrk_data.size() == 0) chk("mrk_vld_unexpected", 1'b0, 1'b1);
        else chk("rd_mrk_data", rd_mrk_data, exp_mrk_data.pop_front());
      end
      if (rd_shi_ack) ev[EV_SHI_ACK]++;
      if (rd_mrk_ack) ev[EV_MRK_ACK]++;
      if (wr_shi_ack) ev[EV_WSHI_ACK]++;
      if (wr_mrk_ack) ev[EV_WMRK_ACK]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic snap();
    for (int i = 0; i < 8; i++) base[i] = ev[i];
  endtask

  task automatic chk_d(input string nm, input int k, input int exp);
    chk(nm, ev[k] - base[k], exp);
  endtask

  task automatic do_reset();
    rd_shi_req = 0; rd_mrk_req = 0; wr_shi_req = 0; wr_mrk_req = 0;
    rd_ack = 0; rd_vld = 0; wr_ack = 0;
    reset = 0;
    tick(2);
    reset = 1;
  endtask

  task automatic rd_request(input logic s, input logic m, input logic [AW-1:0] as, input logic [AW-1:0] am);
    rd_shi_req = s; rd_mrk_req = m;
    if (s) rd_shi_addr = as;
    if (m) rd_mrk_addr = am;
    tick(1);
    rd_shi_req = 0; rd_mrk_req = 0;
  endtask

  task automatic wr_shi(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_shi_req = 1; wr_shi_addr = a; wr_shi_data = d;
    tick(1);
    wr_shi_req = 0;
  endtask

  task automatic wait_rd_req(input string nm);
    int n = 0;
    while (!rd_req && n < 20) begin tick(1); n++; end
    if (!rd_req) chk({nm, "_rd_req_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic wait_wr_req(input string nm);
    int n = 0;
    while (!wr_req && n < 20) begin tick(1); n++; end
    if (!wr_req) chk({nm, "_wr_req_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic serve_rd(input string nm, input int dly);
    wait_rd_req(nm);
    tick(dly);
    rd_ack = 1; tick(1); rd_ack = 0;
  endtask

  task automatic rd_return(input logic [DW-1:0] d);
    rd_vld = 1; rd_data = d; tick(1); rd_vld = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_vld", {rd_shi_vld, rd_mrk_vld}, 0);
    chk("rst_acks", {rd_shi_ack, rd_mrk_ack, wr_shi_ack, wr_mrk_ack}, 0);
    chk("rst_proto_err", proto_err, 0);

    // 1: lone shift read
    snap();
    exp_rd_addr.push_back(19'h00010);
    rd_request(1, 0, 19'h00010, '0);
    serve_rd("t1", 3);
    exp_shi_data.push_back(72'hA5);
    tick(5);
    rd_return(72'hA5);
    tick(3);
    chk_d("t1_rd_req_cnt", EV_RDREQ, 1);
    chk_d("t1_shi_ack_cnt", EV_SHI_ACK, 1);
    chk_d("t1_shi_vld_cnt", EV_SHI_VLD, 1);
    chk_d("t1_mrk_ack_cnt", EV_MRK_ACK, 0);
    chk_d("t1_mrk_vld_cnt", EV_MRK_VLD, 0);

    // 2: simultaneous reads, round-robin and in-order routing
    do_reset();
    snap();
    exp_rd_addr.push_back(19'h10);
    exp_rd_addr.push_back(19'h20);
    rd_request(1, 1, 19'h10, 19'h20);
    serve_rd("t2a", 1);
    serve_rd("t2b", 1);
    exp_shi_data.push_back(72'hD1);
    exp_mrk_data.push_back(72'hD2);
    rd_return(72'hD1);
    rd_return(72'hD2);
    exp_rd_addr.push_back(19'h30);
    rd_request(1, 0, 19'h30, '0);
    serve_rd("t2c", 1);
    exp_rd_addr.push_back(19'h50);
    exp_rd_addr.push_back(19'h40);
    rd_request(1, 1, 19'h40, 19'h50);
    serve_rd("t2d", 1);
    serve_rd("t2e", 1);
    exp_shi_data.push_back(72'hD3);
    exp_mrk_data.push_back(72'hD5);
    exp_shi_data.push_back(72'hD4);
    rd_return(72'hD3);
    rd_return(72'hD5);
    rd_return(72'hD4);
    tick(3);
    chk_d("t2_rd_req_cnt", EV_RDREQ, 5);
    chk_d("t2_shi_vld_cnt", EV_SHI_VLD, 3);
    chk_d("t2_mrk_vld_cnt", EV_MRK_VLD, 2);
    chk_d("t2_mrk_ack_cnt", EV_MRK_ACK, 2);

    // 3: tag FIFO full stalls the ninth read
    do_reset();
    snap();
    for (int i = 0; i < 8; i++) begin
      exp_rd_addr.push_back(19'h100 + 19'(i));
      rd_request(1, 0, 19'h100 + 19'(i), '0);
      serve_rd("t3", 1);
    end
    exp_rd_addr.push_back(19'h108);
    rd_request(1, 0, 19'h108, '0);
    tick(8);
    chk_d("t3_stall_cnt", EV_RDREQ, 8);
    chk("t3_stall_rd_req", rd_req, 0);
    exp_shi_data.push_back(72'hC0);
    rd_return(72'hC0);
    serve_rd("t3_ninth", 1);
    chk_d("t3_after_pop_cnt", EV_RDREQ, 9);
    for (int i = 1; i < 9; i++) begin
      exp_shi_data.push_back(72'hC0 + 72'(i));
      rd_return(72'hC0 + 72'(i));
    end
    tick(3);
    chk_d("t3_shi_vld_cnt", EV_SHI_VLD, 9);
    chk("t3_proto_err", proto_err, 0);

    // 4: read+write together, push/pop in the same cycle
    do_reset();
    snap();
    exp_rd_addr.push_back(19'h60);
    exp_wr_addr.push_back(19'h70);
    exp_wr_data.push_back(72'h1234_5678_9ABC);
    rd_shi_req = 1; rd_shi_addr = 19'h60;
    wr_shi_req = 1; wr_shi_addr = 19'h70; wr_shi_data = 72'h1234_5678_9ABC;
    tick(1);
    rd_shi_req = 0; wr_shi_req = 0;
    wait_rd_req("t4");
    chk("t4_wr_req_same_cycle", wr_req, 1);
    tick(1);
    rd_ack = 1; wr_ack = 1; tick(1); rd_ack = 0; wr_ack = 0;
    exp_rd_addr.push_back(19'h80);
    rd_request(0, 1, '0, 19'h80);
    wait_rd_req("t4b");
    tick(1);
    exp_shi_data.push_back(72'hD6);
    rd_ack = 1; rd_vld = 1; rd_data = 72'hD6;
    tick(1);
    rd_ack = 0; rd_vld = 0;
    exp_mrk_data.push_back(72'hD8);
    tick(1);
    rd_return(72'hD8);
    tick(3);
    chk_d("t4_shi_ack_cnt", EV_SHI_ACK, 1);
    chk_d("t4_wshi_ack_cnt", EV_WSHI_ACK, 1);
    chk_d("t4_mrk_ack_cnt", EV_MRK_ACK, 1);
    chk_d("t4_shi_vld_cnt", EV_SHI_VLD, 1);
    chk_d("t4_mrk_vld_cnt", EV_MRK_VLD, 1);
    chk("t4_proto_err", proto_err, 0);

    // 5a: rd_vld with nothing outstanding
    do_reset();
    snap();
    rd_return(72'hDEAD);
    chk("t5_spurious_proto_err", proto_err, 1);
    tick(3);
    chk_d("t5_spurious_vld", EV_SHI_VLD, 0);
    chk_d("t5_spurious_mvld", EV_MRK_VLD, 0);

    // 5b: duplicate write request while pending
    do_reset();
    snap();
    exp_wr_addr.push_back(19'h200);
    exp_wr_data.push_back(72'h55);
    wr_shi(19'h200, 72'h55);
    wr_shi(19'h201, 72'h66);
    chk("t5_dup_proto_err", proto_err, 1);
    wait_wr_req("t5");
    tick(1);
    wr_ack = 1; tick(1); wr_ack = 0;
    tick(5);
    chk_d("t5_wr_req_cnt", EV_WRREQ, 1);
    chk_d("t5_wshi_ack_cnt", EV_WSHI_ACK, 1);
    chk("t5_proto_err_sticky", proto_err, 1);

    // 6: reset with reads outstanding and one in WAIT_ACK
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_rd_addr.push_back(19'h300 + 19'(i));
      rd_request(1, 0, 19'h300 + 19'(i), '0);
      serve_rd("t6", 1);
    end
    exp_rd_addr.push_back(19'h310);
    rd_request(0, 1, '0, 19'h310);
    wait_rd_req("t6_last");
    tick(2);
    reset = 0;
    tick(1);
    chk("t6_rd_req", rd_req, 0);
    chk("t6_rd_addr", rd_addr, 0);
    chk("t6_acks", {rd_shi_ack, rd_mrk_ack, wr_shi_ack, wr_mrk_ack}, 0);
    chk("t6_vld", {rd_shi_vld, rd_mrk_vld}, 0);
    chk("t6_proto_err", proto_err, 0);
    reset = 1;
    snap();
    tick(1);
    rd_return(72'hBEEF);
    chk("t6_late_vld_proto_err", proto_err, 1);
    tick(3);
    chk_d("t6_late_shi_vld", EV_SHI_VLD, 0);
    chk_d("t6_late_mrk_vld", EV_MRK_VLD, 0);
    chk_d("t6_no_reissue", EV_RDREQ, 0);

    chk("q_rd_addr_empty", exp_rd_addr.size(), 0);
    chk("q_wr_addr_empty", exp_wr_addr.size(), 0);
    chk("q_shi_data_empty", exp_shi_data.size(), 0);
    chk("q_mrk_data_empty", exp_mrk_data.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
